seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Parametrised iterative shift-add multiplier; next generation of the 2-bit combinational
//  multiplier used as a design-space-exploration target. Trades latency for area by retiring
//  STEP multiplier bits per cycle. Supports signed/unsigned mode per operation and
//  valid/ready handshakes on both sides, so the RL exploration harness can sweep WIDTH and STEP.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
//  STEP   1  multiplier bits consumed per cycle (1,2,4); WIDTH % STEP == 0 is required
// PORTS
//  clk        in   1          rising-edge clock, the only clock
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block can accept an operand pair
//  in_signed  in   1          1 = two's-complement operands, 0 = unsigned; sampled with A/B
//  A          in   WIDTH      multiplicand
//  B          in   WIDTH      multiplier
//  abort      in   1          synchronous cancel of the operation in flight
//  out_valid  out  1          P holds a completed product
//  out_ready  in   1          consumer accepts P
//  P          out  2*WIDTH    product (signed or unsigned per captured in_signed)
//  busy       out  1          high in BUSY or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=0 while rst_n low, then 1 in IDLE;
//   out_valid=0, busy=0, P=0, all internal registers cleared.
//  FSM: IDLE -> BUSY when in_valid&&in_ready (accept); BUSY -> DONE after N=WIDTH/STEP
//   iterations; DONE -> IDLE when out_valid&&out_ready. abort in BUSY or DONE -> IDLE
//   next cycle; the product is discarded and out_valid is forced to 0.
//  in_ready = (state==IDLE). No operand acceptance in the cycle DONE is consumed; the next
//   accept occurs one cycle later.
//  Accept cycle: latch in_signed and sign flag s = in_signed & (A[W-1]^B[W-1]); latch
//   magnitudes |A| and |B| (unsigned mode: raw values); clear accumulator and iteration counter.
//  BUSY iteration: acc += |A| * B_shift[STEP-1:0], weighted by 2^(STEP*i); B_shift >>= STEP;
//   i increments. Exactly N cycles in BUSY.
//  Entering DONE: P = s ? -acc : acc (2*WIDTH-bit two's complement). out_valid=1.
//   P is held stable while out_valid=1 && out_ready=0.
//  Latency: out_valid rises N+1 cycles after the accept edge (WIDTH=8, STEP=1: 9 cycles).
//  Width rules: magnitude of -2^(W-1) is 2^(W-1), held in W unsigned bits without overflow.
//   The full product always fits in 2*WIDTH bits; no saturation and no truncation.
//  Zero operand: still runs N cycles; P=0 (never -0 artefacts), even if s=1.
//  abort together with out_ready in DONE: abort wins, and the product is not delivered.
//  abort in IDLE: ignored; in_ready is unaffected.
//  in_valid while busy: ignored; A/B/in_signed are not sampled.
//  rst_n asserted mid-operation: immediate return to the reset values; no partial P is shown.
// TESTING
//  T1 WIDTH=2,STEP=1 exhaustive unsigned A,B in 0..3 -> P=A*B (e.g. 3*3=9, 2*2=4), out_valid at cycle 3.
//  T2 WIDTH=8,STEP=1 signed A=-128,B=-128 -> P=16'h4000; A=-1,B=127 -> P=16'hFF81; A=0,B=-5 -> P=0.
//  T3 WIDTH=8,STEP=4 unsigned A=255,B=255 -> P=16'hFE01, out_valid 3 cycles after accept.
//  T4 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> P stable, in_ready=0;
//     release -> IDLE next cycle, then a new accept succeeds.
//  T5 Drop rst_n in BUSY, iteration 3 -> out_valid=0, P=0, busy=0 immediately; after release,
//     in_ready=1 and A=7,B=6 -> P=42.
//  T6 abort in BUSY and abort together with out_ready in DONE -> no out_valid pulse,
//     IDLE next cycle; in_valid asserted while busy is ignored (no second product).

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: retires STEP multiplier bits per cycle on sign-magnitude
// operands, restores the sign once on entry to DONE. Valid/ready on both sides, sync abort.
module seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_C = CW'(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   a_sh;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     b_sh;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic                 accept;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   pp, prod;

    assign accept = in_valid && in_ready;
    // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exact as an unsigned W-bit value.
    assign mag_a  = (in_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign mag_b  = (in_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign prod   = neg ? (~acc + 1'b1) : acc;

    // a_sh already carries the 2^(STEP*i) weight, so one digit only needs STEP local shifts.
    always_comb begin
        pp = '0;
        for (int k = 0; k < STEP; k++)
            if (b_sh[k]) pp = pp + (a_sh << k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            P         <= '0;
            a_sh      <= '0;
            acc       <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        a_sh     <= {{WIDTH{1'b0}}, mag_a};
                        b_sh     <= mag_b;
                        acc      <= '0;
                        cnt      <= '0;
                        neg      <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        P        <= '0;
                    end else if (cnt == N_C) begin
                        state     <= DONE;
                        P         <= prod;
                        out_valid <= 1'b1;
                    end else begin
                        acc  <= acc + pp;
                        a_sh <= a_sh << STEP;
                        b_sh <= b_sh >> STEP;
                        cnt  <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        P         <= '0;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=8/STEP=1 main instance plus WIDTH=2/STEP=1 and
// WIDTH=8/STEP=4 instances for exhaustive small-width and multi-bit-step checks.
module tb_seq_multiplier;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // main instance
    logic        rst_n = 1'b0;
    logic        in_valid = 0, in_signed = 0, abort = 0, out_ready = 0;
    logic [7:0]  a = 0, b = 0;
    logic        in_ready, out_valid, busy;
    logic [15:0] p;

    seq_multiplier #(.WIDTH(8), .STEP(1)) d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .A(a), .B(b), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .P(p), .busy(busy));

    // narrow instance
    logic       v2 = 0, s2 = 0;
    logic [1:0] a2 = 0, b2 = 0;
    logic       r2, ov2, bz2;
    logic [3:0] p2;

    seq_multiplier #(.WIDTH(2), .STEP(1)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
        .in_signed(s2), .A(a2), .B(b2), .abort(1'b0), .out_valid(ov2),
        .out_ready(1'b1), .P(p2), .busy(bz2));

    // STEP=4 instance
    logic        v4 = 0, s4 = 0;
    logic [7:0]  a4 = 0, b4 = 0;
    logic        r4, ov4, bz4;
    logic [15:0] p4;

    seq_multiplier #(.WIDTH(8), .STEP(4)) d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .in_signed(s4), .A(a4), .B(b4), .abort(1'b0), .out_valid(ov4),
        .out_ready(1'b1), .P(p4), .busy(bz4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (!in_ready) chk("in_ready timeout", 0, 1);
    endtask

    // accept one operation on d8; leaves bench just after the accept edge
    task automatic start8(input logic sg, input logic [7:0] x, input logic [7:0] y);
        wait_ready8();
        in_signed = sg; a = x; b = y; in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_done8(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        if (!out_valid) chk({tag, " timeout"}, 0, 1);
    endtask

    task automatic mul8(input string tag, input logic sg, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp);
        int lat;
        start8(sg, x, y);
        wait_done8(tag, lat);
        chk({tag, " lat"}, lat, 9);
        chk({tag, " P"}, p, exp);
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic mul2(input logic [1:0] x, input logic [1:0] y);
        int lat = 0;
        while (!r2 && lat < 20) begin tick(); lat++; end
        a2 = x; b2 = y; v2 = 1;
        tick();
        v2 = 0;
        lat = 0;
        while (!ov2 && lat < 20) begin tick(); lat++; end
        chk($sformatf("w2 %0d*%0d lat", x, y), lat, 3);
        chk($sformatf("w2 %0d*%0d P", x, y), p2, 4'(x * y));
        tick();
    endtask

    int lat, pulses;
    logic [15:0] held;

    initial begin
        // reset state
        #2;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst P", p, 0);
        tick();
        chk("rst held in_ready", in_ready, 0);
        rst_n = 1;
        tick();
        chk("idle in_ready", in_ready, 1);

        // abort in IDLE ignored
        abort = 1;
        tick();
        abort = 0;
        chk("idle abort in_ready", in_ready, 1);
        chk("idle abort busy", busy, 0);

        // T2 signed and unsigned vectors
        mul8("s -128*-128", 1, 8'h80, 8'h80, 16'h4000);
        mul8("s -1*127",    1, 8'hFF, 8'h7F, 16'hFF81);
        mul8("s 0*-5",      1, 8'h00, 8'hFB, 16'h0000);
        mul8("s -3*5",      1, 8'hFD, 8'h05, 16'hFFF1);
        mul8("s -128*1",    1, 8'h80, 8'h01, 16'hFF80);
        mul8("u 200*3",     0, 8'hC8, 8'h03, 16'h0258);
        mul8("u 255*255",   0, 8'hFF, 8'hFF, 16'hFE01);

        // T4 backpressure
        start8(0, 8'd13, 8'd11);
        wait_done8("bp", lat);
        held = p;
        chk("bp P", held, 16'd143);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold P", p, 16'd143);
            chk("bp hold valid", out_valid, 1);
            chk("bp in_ready", in_ready, 0);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp release valid", out_valid, 0);
        chk("bp release in_ready", in_ready, 1);
        chk("bp release busy", busy, 0);
        mul8("bp next", 0, 8'd9, 8'd9, 16'd81);

        // T5 reset mid-operation
        start8(0, 8'd100, 8'd100);
        tick(); tick(); tick();
        chk("t5 busy before", busy, 1);
        rst_n = 0;
        #1;
        chk("t5 out_valid", out_valid, 0);
        chk("t5 P", p, 0);
        chk("t5 busy", busy, 0);
        chk("t5 in_ready", in_ready, 0);
        tick();
        rst_n = 1;
        tick();
        chk("t5 in_ready after", in_ready, 1);
        mul8("t5 7*6", 0, 8'd7, 8'd6, 16'd42);

        // T6 abort in BUSY, with ignored in_valid while busy
        start8(0, 8'd5, 8'd5);
        a = 8'd9; b = 8'd9; in_valid = 1;
        tick(); tick();
        in_valid = 0;
        abort = 1;
        tick();
        abort = 0;
        chk("t6a out_valid", out_valid, 0);
        chk("t6a busy", busy, 0);
        chk("t6a in_ready", in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (out_valid) pulses++; end
        chk("t6a no pulse", pulses, 0);

        // abort together with out_ready in DONE
        start8(0, 8'd3, 8'd4);
        wait_done8("t6b", lat);
        abort = 1; out_ready = 1;
        tick();
        abort = 0; out_ready = 0;
        chk("t6b out_valid", out_valid, 0);
        chk("t6b busy", busy, 0);
        chk("t6b in_ready", in_ready, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (out_valid) pulses++; end
        chk("t6b no pulse", pulses, 0);
        mul8("t6 after", 1, 8'hFE, 8'h03, 16'hFFFA);

        // T1 exhaustive WIDTH=2
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                mul2(2'(x), 2'(y));

        // T3 STEP=4
        lat = 0;
        while (!r4 && lat < 20) begin tick(); lat++; end
        a4 = 8'hFF; b4 = 8'hFF; v4 = 1;
        tick();
        v4 = 0;
        lat = 0;
        while (!ov4 && lat < 20) begin tick(); lat++; end
        chk("s4 lat", lat, 3);
        chk("s4 P", p4, 16'hFE01);
        tick();
        s4 = 1; a4 = 8'h80; b4 = 8'h7F; v4 = 1;
        tick();
        v4 = 0;
        lat = 0;
        while (!ov4 && lat < 20) begin tick(); lat++; end
        chk("s4 signed lat", lat, 3);
        chk("s4 signed P", p4, 16'hC080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
